// File: rtl/ec_point_add_double.sv
// Affine point add/double over GF(p) for short-Weierstrass curves, with
// infinity handling, start/busy/done handshake and an iterative binary inverter.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// IDLE     | waiting for start (busy stays high during the done cycle)
// CLASSIFY | pick passthrough / add / double / infinity, seed the inverter
// INV      | one binary extended-Euclid step per cycle
// LAMBDA   | lam = num * den^-1
// XCALC    | x = lam^2 - x1 - x2
// YCALC    | y = lam * (x1 - x) - y1
// FINISH   | load result registers, raise done next cycle
module ec_point_add_double #(
  parameter int n       = 231,
  parameter int INV_MAX = 2*n+2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic         inf1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  input  logic         inf2,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         inf3,
  output logic         err
);

  localparam int CW = $clog2(INV_MAX+1);
  localparam logic [CW-1:0] CNT_INIT = CW'(INV_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [n:0]    ONE_W    = (n+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_INV, S_LAMBDA, S_XCALC, S_YCALC, S_FINISH
  } state_t;

  typedef enum logic [2:0] {K_Q, K_P, K_ADD, K_DBL, K_INF} kind_t;

  function automatic logic [n-1:0] mod_add(input logic [n-1:0] x, input logic [n-1:0] y,
                                           input logic [n-1:0] m);
    logic [n:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return n'(s);
  endfunction

  // Borrow is repaired by adding m in n+1 bits, so the result never wraps at 2^n.
  function automatic logic [n-1:0] mod_sub(input logic [n-1:0] x, input logic [n-1:0] y,
                                           input logic [n-1:0] m);
    logic [n:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + {1'b0, m};
    return n'(d);
  endfunction

  function automatic logic [n-1:0] mod_mul(input logic [n-1:0] x, input logic [n-1:0] y,
                                           input logic [n-1:0] m);
    logic [2*n-1:0] prod;
    prod = {{n{1'b0}}, x} * {{n{1'b0}}, y};
    return n'(prod % {{n{1'b0}}, m});
  endfunction

  function automatic logic [n-1:0] mod_half(input logic [n-1:0] x, input logic [n-1:0] m);
    logic [n:0] h;
    h = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
    return n'(h >> 1);
  endfunction

  state_t state_q, state_d;
  kind_t  kind;

  logic [n-1:0] p_r, a_r, x1_r, y1_r, x2_r, y2_r;
  logic         inf1_r, inf2_r;
  logic [n-1:0] num_r, lam_r, xr, yr;
  logic         res_inf;
  logic [n:0]   u_r, v_r, u_n, v_n;
  logic [n-1:0] r_r, s_r, r_n, s_n;
  logic [CW-1:0] cnt_r;
  logic         busy_r, done_r, err_r, inf3_r;
  logic [n-1:0] x3_r, y3_r;

  logic [n-1:0] x1_sq, cls_num, cls_den, inv_sel, lam_sq, x_new, y_new;
  logic         accept, inv_exit, cnt_last;

  assign accept   = start && !busy_r;
  assign x1_sq    = mod_mul(x1_r, x1_r, p_r);
  assign inv_sel  = (u_r == ONE_W) ? r_r : s_r;
  assign lam_sq   = mod_mul(lam_r, lam_r, p_r);
  assign x_new    = mod_sub(mod_sub(lam_sq, x1_r, p_r), x2_r, p_r);
  assign y_new    = mod_sub(mod_mul(lam_r, mod_sub(x1_r, xr, p_r), p_r), y1_r, p_r);
  assign inv_exit = (u_n == ONE_W) || (v_n == ONE_W);
  assign cnt_last = (cnt_r == CNT_ONE);

  always_comb begin
    kind    = K_INF;
    cls_num = '0;
    cls_den = '0;
    if (inf1_r) begin
      kind = K_Q;
    end else if (inf2_r) begin
      kind = K_P;
    end else if (x1_r != x2_r) begin
      kind    = K_ADD;
      cls_num = mod_sub(y2_r, y1_r, p_r);
      cls_den = mod_sub(x2_r, x1_r, p_r);
    end else if (y1_r == y2_r && y1_r != '0) begin
      kind    = K_DBL;
      cls_num = mod_add(mod_add(mod_add(x1_sq, x1_sq, p_r), x1_sq, p_r), a_r, p_r);
      cls_den = mod_add(y1_r, y1_r, p_r);
    end
  end

  // Invariant kept by every step: r*den == u and s*den == v (mod p).
  always_comb begin
    u_n = u_r;
    v_n = v_r;
    r_n = r_r;
    s_n = s_r;
    if (!u_r[0]) begin
      u_n = u_r >> 1;
      r_n = mod_half(r_r, p_r);
    end else if (!v_r[0]) begin
      v_n = v_r >> 1;
      s_n = mod_half(s_r, p_r);
    end else if (u_r >= v_r) begin
      u_n = u_r - v_r;
      r_n = mod_sub(r_r, s_r, p_r);
    end else begin
      v_n = v_r - u_r;
      s_n = mod_sub(s_r, r_r, p_r);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = S_CLASSIFY;
      S_CLASSIFY: state_d = (kind == K_ADD || kind == K_DBL) ? S_INV : S_FINISH;
      S_INV: begin
        if (inv_exit)      state_d = S_LAMBDA;
        else if (cnt_last) state_d = S_FINISH;
      end
      S_LAMBDA:   state_d = S_XCALC;
      S_XCALC:    state_d = S_YCALC;
      S_YCALC:    state_d = S_FINISH;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_r <= '0; a_r <= '0; x1_r <= '0; y1_r <= '0; x2_r <= '0; y2_r <= '0;
      inf1_r <= 1'b0; inf2_r <= 1'b0;
      num_r <= '0; lam_r <= '0; xr <= '0; yr <= '0; res_inf <= 1'b0;
      u_r <= '0; v_r <= '0; r_r <= '0; s_r <= '0; cnt_r <= '0;
      busy_r <= 1'b0; done_r <= 1'b0; err_r <= 1'b0;
      x3_r <= '0; y3_r <= '0; inf3_r <= 1'b0;
    end else begin
      done_r <= (state_q == S_FINISH);
      if (accept) begin
        busy_r <= 1'b1;
        err_r  <= 1'b0;
        p_r    <= p;  a_r  <= a;
        x1_r   <= x1; y1_r <= y1; inf1_r <= inf1;
        x2_r   <= x2; y2_r <= y2; inf2_r <= inf2;
      end else if (done_r) begin
        busy_r <= 1'b0;
      end
      case (state_q)
        S_CLASSIFY: begin
          num_r   <= cls_num;
          u_r     <= {1'b0, cls_den};
          v_r     <= {1'b0, p_r};
          r_r     <= n'(1);
          s_r     <= '0;
          cnt_r   <= CNT_INIT;
          res_inf <= 1'b0;
          case (kind)
            K_Q:     begin xr <= x2_r; yr <= y2_r; res_inf <= inf2_r; end
            K_P:     begin xr <= x1_r; yr <= y1_r; end
            K_INF:   res_inf <= 1'b1;
            default: ;
          endcase
        end
        S_INV: begin
          u_r <= u_n; v_r <= v_n; r_r <= r_n; s_r <= s_n;
          cnt_r <= cnt_r - CNT_ONE;
          if (!inv_exit && cnt_last) begin
            err_r   <= 1'b1;
            res_inf <= 1'b1;
          end
        end
        S_LAMBDA: lam_r <= mod_mul(num_r, inv_sel, p_r);
        S_XCALC:  xr <= x_new;
        S_YCALC:  yr <= y_new;
        S_FINISH: begin
          x3_r   <= res_inf ? '0 : xr;
          y3_r   <= res_inf ? '0 : yr;
          inf3_r <= res_inf;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign x3   = x3_r;
  assign y3   = y3_r;
  assign inf3 = inf3_r;
  assign err  = err_r;

endmodule

// File: tb/tb_ec_point_add_double.sv
// Self-checking bench for ec_point_add_double (n=8): directed curve cases plus
// randomized operands over several primes, checked against a plain-integer EC model.
module tb_ec_point_add_double;
  localparam int N       = 8;
  localparam int INV_MAX = 2*N+2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] p = '0, a = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic         inf1 = 1'b0, inf2 = 1'b0;
  logic         busy, done, inf3, err;
  logic [N-1:0] x3, y3;

  ec_point_add_double #(.n(N), .INV_MAX(INV_MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .p(p), .a(a),
    .x1(x1), .y1(y1), .inf1(inf1), .x2(x2), .y2(y2), .inf2(inf2),
    .busy(busy), .done(done), .x3(x3), .y3(y3), .inf3(inf3), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int x;
    int y;
    int i;
    bit triv;
    int t0;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Point sum from the group-law rules; the inverse is found by exhaustive search.
  function automatic void ec_model(input int pp, input int aa,
                                   input int xa, input int ya, input int ia,
                                   input int xb, input int yb, input int ib,
                                   output int rx, output int ry, output int ri,
                                   output bit triv);
    int num, den, inv, lam;
    rx = 0; ry = 0; ri = 0; triv = 1'b1;
    num = 0; den = 0; inv = 0;
    if (ia != 0) begin
      ri = ib;
      if (ib == 0) begin rx = xb; ry = yb; end
      return;
    end
    if (ib != 0) begin rx = xa; ry = ya; return; end
    if (xa != xb) begin
      num = (yb - ya + pp) % pp;
      den = (xb - xa + pp) % pp;
    end else if (ya == yb && ya != 0) begin
      num = (3*xa*xa + aa) % pp;
      den = (2*ya) % pp;
    end else begin
      ri = 1;
      return;
    end
    triv = 1'b0;
    for (int k = 1; k < pp; k++) if ((den*k) % pp == 1) inv = k;
    lam = (num*inv) % pp;
    rx = (((lam*lam - xa - xb) % pp) + pp) % pp;
    ry = (((lam*((xa - rx + pp) % pp) - ya) % pp) + pp) % pp;
  endfunction

  // Single compare process: every done pulse is matched to the oldest accepted request.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      check("done_single_cycle", int'(prev_done), 0);
      check("busy_during_done", int'(busy), 1);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("x3", int'(x3), e.x);
        check("y3", int'(y3), e.y);
        check("inf3", int'(inf3), e.i);
        check("err", int'(err), 0);
        if (e.triv) check("latency_trivial", cyc - e.t0, 3);
        else begin
          check("latency_min", int'((cyc - e.t0) >= 6), 1);
          check("latency_max", int'((cyc - e.t0) <= 6 + INV_MAX), 1);
        end
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int pp, input int aa, input int xa, input int ya, input int ia,
                       input int xb, input int yb, input int ib);
    exp_t e;
    wait_idle();
    p = N'(pp); a = N'(aa);
    x1 = N'(xa); y1 = N'(ya); inf1 = ia[0];
    x2 = N'(xb); y2 = N'(yb); inf2 = ib[0];
    start = 1'b1;
    ec_model(pp, aa, xa, ya, ia, xb, yb, ib, e.x, e.y, e.i, e.triv);
    e.t0 = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 1, 0);
  endtask

  initial begin
    #(60000 * 10);
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int primes[9] = '{5, 7, 13, 17, 101, 127, 191, 223, 251};

  initial begin
    int rx, ry, ri;
    bit tv;

    // Pin the model against hand-derived points on y^2 = x^3+2x+2 over GF(17).
    ec_model(17, 2, 5, 1, 0, 5, 1, 0, rx, ry, ri, tv);
    check("model_dbl_x", rx, 6); check("model_dbl_y", ry, 3); check("model_dbl_inf", ri, 0);
    ec_model(17, 2, 5, 1, 0, 6, 3, 0, rx, ry, ri, tv);
    check("model_add_x", rx, 10); check("model_add_y", ry, 6);
    ec_model(17, 2, 6, 3, 0, 5, 1, 0, rx, ry, ri, tv);
    check("model_swap_x", rx, 10); check("model_swap_y", ry, 6);
    ec_model(17, 2, 5, 1, 0, 5, 16, 0, rx, ry, ri, tv);
    check("model_inverse_inf", ri, 1);
    ec_model(17, 2, 3, 0, 0, 3, 0, 0, rx, ry, ri, tv);
    check("model_dbl_y0_inf", ri, 1);

    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x3", int'(x3), 0);
    check("rst_y3", int'(y3), 0);
    check("rst_inf3", int'(inf3), 0);
    check("rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(17, 2, 5, 1, 0, 5, 1, 0);
    issue(17, 2, 5, 1, 0, 6, 3, 0);
    issue(17, 2, 6, 3, 0, 5, 1, 0);
    issue(17, 2, 5, 1, 0, 5, 16, 0);
    issue(17, 2, 0, 0, 1, 6, 3, 0);
    issue(17, 2, 0, 0, 1, 0, 0, 1);
    issue(17, 2, 3, 0, 0, 3, 0, 0);
    issue(17, 2, 6, 3, 0, 0, 0, 1);

    // Second start while busy must neither relatch nor queue a new result.
    issue(17, 2, 5, 1, 0, 5, 1, 0);
    x1 = N'(6); y1 = N'(3); x2 = N'(10); y2 = N'(6); start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;

    // Start coinciding with done is ignored.
    wait_done();
    x1 = N'(5); y1 = N'(1); x2 = N'(6); y2 = N'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("start_on_done_ignored_busy", int'(busy), 0);
    check("start_on_done_ignored_queue", q.size(), 0);

    // Reset in the middle of the inverter.
    issue(17, 2, 5, 1, 0, 5, 1, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_x3", int'(x3), 0);
    check("abort_y3", int'(y3), 0);
    check("abort_inf3", int'(inf3), 0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", int'(done), 0);
    issue(17, 2, 5, 1, 0, 5, 1, 0);

    // Randomized operands over several primes; back-to-back or gapped.
    for (int t = 0; t < 120; t++) begin
      int pp, aa, xa, ya, ia, xb, yb, ib, mode;
      pp = primes[$urandom_range(0, 8)];
      aa = int'($urandom_range(0, pp-1));
      xa = int'($urandom_range(0, pp-1)); ya = int'($urandom_range(0, pp-1));
      xb = int'($urandom_range(0, pp-1)); yb = int'($urandom_range(0, pp-1));
      ia = 0; ib = 0;
      mode = int'($urandom_range(0, 9));
      case (mode)
        0: ia = 1;
        1: ib = 1;
        2: begin ia = 1; ib = 1; end
        3, 4: begin xb = xa; yb = ya; end
        5: begin xb = xa; yb = (pp - ya) % pp; end
        6: begin ya = 0; xb = xa; yb = 0; end
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(pp, aa, xa, ya, ia, xb, yb, ib);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ec_point_add_double.md
Name: ec_point_add_double

Overview:
- Unified affine point addition/doubling unit over GF(p) for short-Weierstrass curves y^2 = x^3 + a*x + b.
- Successor to the single-mode adder. Adds:
  - automatic add/double selection;
  - point-at-infinity inputs and outputs;
  - a start/busy/done handshake;
  - an internal iterative binary modular inverter.
- The scalar-multiplication controller drives it and reuses it for every ladder step.

Parameters:
- n, 231, operand width in bits; p < 2^n.
- INV_MAX, 2*n+2, cycle bound for the inverter; the inverter aborts with err if exceeded.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; operands are sampled when start=1 and busy=0.
- p  in  n  odd prime modulus > 3; held stable while busy.
- a  in  n  curve coefficient a, < p.
- x1, y1  in  n  point P, coordinates < p.
- inf1  in  1  P is the point at infinity.
- x2, y2  in  n  point Q, coordinates < p.
- inf2  in  1  Q is the point at infinity.
- busy  out  1  operation in progress.
- done  out  1  single-cycle pulse; results are valid from this cycle.
- x3, y3  out  n  result R = P + Q; held until the next start.
- inf3  out  1  R is the point at infinity.
- err  out  1  inverter exceeded INV_MAX; sticky until the next start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, inf3, err = 0; x3, y3 = 0.
- Release is synchronous to clk.
- On accepted start: latch all operands, set busy=1, clear err, go to CLASSIFY.
- start while busy=1 is ignored (no relatch, no effect).
- CLASSIFY (1 cycle), priority order:
  1. inf1 -> R = Q (including inf2).
  2. inf2 -> R = P.
  3. x1 != x2 -> ADD: num = (y2 - y1) mod p, den = (x2 - x1) mod p.
  4. y1 == y2 and y1 != 0 -> DBL: num = (3*x1^2 + a) mod p, den = 2*y1 mod p.
  5. Otherwise (y1 == p - y2, or DBL with y1 = 0) -> R = infinity.
  - Cases 1, 2 and 5 go straight to FINISH.
  - Cases 3 and 4 go to INV.
- INV (binary extended Euclid, one step per cycle):
  - Init: u = den, v = p, r = 1, s = 0.
  - Each cycle:
    - u even: u >>= 1, r = r even ? r/2 : (r+p)/2.
    - else v even: same step on v and s.
    - else u >= v: u -= v, r = (r - s) mod p.
    - else: v -= u, s = (s - r) mod p.
  - Exit when u == 1 (inv = r) or v == 1 (inv = s).
  - Intermediates are n+1 bits wide.
  - Cycle counter reaching INV_MAX -> err=1, R = infinity, go to FINISH.
- LAMBDA (1 cycle): lam = num*inv mod p; products are 2n bits wide, then reduced.
- XCALC (1 cycle): x3 = (lam^2 - x1 - x2) mod p.
  - For DBL, x2 = x1.
  - Each subtraction adds p when it would go negative.
- YCALC (1 cycle): y3 = (lam*((x1 - x3) mod p) - y1) mod p.
  - If the subtraction would underflow, add p; never wrap at 2^n.
- FINISH (1 cycle):
  - Drive the x3, y3, inf3 registers.
  - For an infinity result: x3 = y3 = 0, inf3 = 1.
  - done=1 this cycle only; busy=0 from the next cycle; state returns to IDLE.
- Latency:
  - Trivial cases: start -> done = 3 cycles.
  - ADD/DBL: 6 + inverter steps (<= 2n).
- Outputs are always in [0, p-1]; no X or Z is ever driven.
- Reset mid-operation aborts immediately; no done pulse is produced.
- start in the same cycle as done (busy still 1) is ignored; the controller issues start one cycle later.

Test Plan (n=8, p=17, a=2; curve y^2 = x^3+2x+2, G=(5,1)):
- DBL: start, P=Q=(5,1) -> done, R=(6,3), inf3=0, err=0.
- ADD: P=(5,1), Q=(6,3) -> R=(10,6). Swapping the operands gives the same R.
- Inverse points: P=(5,1), Q=(5,16) -> inf3=1, x3=y3=0, done exactly 3 cycles after start.
- Infinity passthrough:
  - inf1=1, Q=(6,3) -> R=(6,3).
  - inf1=inf2=1 -> inf3=1.
  - DBL with (3,0) -> inf3=1.
- Handshake:
  - Second start while busy is ignored; result still (6,3).
  - Back-to-back operations, with start one cycle after done, both complete correctly.
- Abort: assert reset mid-INV -> busy=0, done=0, outputs 0. A new DBL (5,1) then yields (6,3).
